// File: rtl/axi4_lite_ram_slave.sv
// AXI4-Lite data-RAM target: word-organised memory with byte strobes, independent
// write/read state machines, SLVERR for addresses outside the RAM window.
module axi4_lite_ram_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);

  // Handshake rule on every channel: a transfer happens on the rising edge where
  // valid and ready are both high; once raised, valid and its payload stay put
  // until that edge. This block raises ready/valid purely from registered state.

  localparam int                  IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [1:0]          RESP_OKAY  = 2'b00;
  localparam logic [1:0]          RESP_SLVERR = 2'b10;
  localparam logic [ADDR_WIDTH:0] BASE_EXT   = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] LIMIT_EXT  = BASE_EXT + ((ADDR_WIDTH+1)'(DEPTH_WORDS) << 2);

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_RESP } r_state_e;

  // One extra bit keeps the upper bound exact when the window ends at the top of the map.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= BASE_EXT) && ({1'b0, a} < LIMIT_EXT);
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  // Readies stay low during reset and for the first cycle after release.
  logic rdy_en_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdy_en_q <= 1'b0;
    else      rdy_en_q <= 1'b1;
  end

  // ---------------- write channel ----------------
  w_state_e              w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  aw_hs, w_hs, wr_commit, wr_in_range, mem_we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic [IDX_W-1:0]      wr_idx;

  assign awready = rdy_en_q && (w_state_q == W_IDLE) && !aw_held_q;
  assign wready  = rdy_en_q && (w_state_q == W_IDLE) && !w_held_q;
  assign bvalid  = (w_state_q == W_RESP);
  assign bresp   = bresp_q;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  // A half arriving on the commit edge is used directly; an earlier one comes from its latch.
  assign wr_addr     = aw_held_q ? awaddr_q : awaddr;
  assign wr_data     = w_held_q  ? wdata_q  : wdata;
  assign wr_strb     = w_held_q  ? wstrb_q  : wstrb;
  assign wr_in_range = addr_in_range(wr_addr);
  assign wr_idx      = word_index(wr_addr);
  assign mem_we      = wr_commit && wr_in_range;

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    bresp_d   = bresp_q;
    wr_commit = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) aw_held_d = 1'b1;
        if (w_hs)  w_held_d  = 1'b1;
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          wr_commit = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) w_state_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) awaddr_q <= awaddr;
    if (w_hs) begin
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e         r_state_q, r_state_d;
  logic [31:0]      rdata_q;
  logic [1:0]       rresp_q;
  logic             ar_hs, rd_in_range;
  logic [IDX_W-1:0] rd_idx;

  assign arready     = rdy_en_q && (r_state_q == R_IDLE);
  assign rvalid      = (r_state_q == R_RESP);
  assign rdata       = rdata_q;
  assign rresp       = rresp_q;
  assign ar_hs       = arvalid && arready;
  assign rd_in_range = addr_in_range(araddr);
  assign rd_idx      = word_index(araddr);

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE: if (ar_hs)  r_state_d = R_RESP;
      R_RESP: if (rready) r_state_d = R_IDLE;
    endcase
  end

  // The capture samples mem before this edge's write lands, giving read-first collisions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        rdata_q <= rd_in_range ? mem[rd_idx] : '0;
        rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_ram_slave.sv
// Self-checking bench for axi4_lite_ram_slave: directed scenarios plus randomized
// traffic against a word-array model of the RAM window.
module tb_axi4_lite_ram_slave;

  localparam int          AW    = 32;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic          clk, rst;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [0:DEPTH-1];
  logic [33:0] exp_q [$];

  axi4_lite_ram_slave #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time limit, required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic bit model_in_range(input logic [31:0] a);
    longint la, lb;
    la = longint'(a);
    lb = longint'(BASE);
    return (la >= lb) && (la < lb + DEPTH * 4);
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                             input logic [3:0] s);
    int idx;
    if (!model_in_range(a)) return 2'b10;
    idx = int'((a - BASE) / 4);
    for (int b = 0; b < 4; b++)
      if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic logic [1:0] model_read(input logic [31:0] a, output logic [31:0] d);
    if (!model_in_range(a)) begin
      d = 32'h0;
      return 2'b10;
    end
    d = model_mem[int'((a - BASE) / 4)];
    return 2'b00;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp);
    int cyc;
    bit aw_done, w_done, aw_f, w_f, got;
    resp = 2'bxx; cyc = 0; aw_done = 0; w_done = 0; got = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (!aw_done && cyc >= aw_dly) begin awaddr = addr; awvalid = 1'b1; end
      if (!w_done && cyc >= w_dly) begin wdata = data; wstrb = strb; wvalid = 1'b1; end
      @(negedge clk);
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_f) begin aw_done = 1; awvalid = 1'b0; end
      if (w_f)  begin w_done = 1;  wvalid  = 1'b0; end
      cyc++;
    end
    n_checks++;
    if (!(aw_done && w_done)) begin
      n_fail++;
      $display("FAIL write_accept: aw_done=%0b w_done=%0b after %0d cycles, required both 1", aw_done, w_done, cyc);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    cyc = 0;
    while (!got && cyc < 40) begin
      if (cyc >= b_dly) bready = 1'b1;
      @(negedge clk);
      if (bvalid && bready) begin got = 1; resp = bresp; end
      @(posedge clk); #1;
      cyc++;
    end
    bready = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL write_response_timeout: bvalid=%0b after %0d cycles, required 1", bvalid, cyc);
    end
  endtask

  task automatic read_txn(input logic [31:0] addr, input int ar_dly, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    int cyc;
    bit done, got;
    data = 'x; resp = 2'bxx; cyc = 0; done = 0; got = 0;
    while (!done && cyc < 40) begin
      if (cyc >= ar_dly) begin araddr = addr; arvalid = 1'b1; end
      @(negedge clk);
      done = arvalid && arready;
      @(posedge clk); #1;
      if (done) arvalid = 1'b0;
      cyc++;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL read_accept: arready never seen in %0d cycles, required handshake", cyc);
      arvalid = 1'b0;
      return;
    end
    cyc = 0;
    while (!got && cyc < 40) begin
      if (cyc >= r_dly) rready = 1'b1;
      @(negedge clk);
      if (rvalid && rready) begin got = 1; data = rdata; resp = rresp; end
      @(posedge clk); #1;
      cyc++;
    end
    rready = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL read_response_timeout: rvalid=%0b after %0d cycles, required 1", rvalid, cyc);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    #2;
    n_checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_handshakes: aw/w/ar ready,b/r valid=%b required 00000", {awready, wready, arready, bvalid, rvalid});
    end
    n_checks++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_payload: bresp=%b rresp=%b rdata=%h required 00 00 00000000", bresp, rresp, rdata);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_release_ready: aw/w/ar ready=%b required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_word_store();
    logic [31:0] d;
    logic [1:0]  r;
    awaddr = BASE + 32'h10; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 0;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    void'(model_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF));
    n_checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      n_fail++;
      $display("FAIL store_latency: bvalid=%b bresp=%b one cycle after AW+W, required 1 00", bvalid, bresp);
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    n_checks++;
    if (bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL store_b_done: bvalid=%b after B handshake, required 0", bvalid);
    end
    araddr = BASE + 32'h10; arvalid = 1;
    @(posedge clk); #1;
    arvalid = 0;
    r = model_read(BASE + 32'h10, d);
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF || rresp !== r) begin
      n_fail++;
      $display("FAIL load_word: rvalid=%b rdata=%h rresp=%b required 1 deadbeef %b", rvalid, rdata, rresp, r);
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic test_strobes();
    logic [31:0] d;
    logic [1:0]  r;
    write_txn(BASE + 32'h10, 32'h1122_3344, 4'hF, 0, 0, 0, r);
    void'(model_write(BASE + 32'h10, 32'h1122_3344, 4'hF));
    write_txn(BASE + 32'h12, 32'h00AA_0000, 4'b0100, 0, 0, 0, r);
    void'(model_write(BASE + 32'h12, 32'h00AA_0000, 4'b0100));
    read_txn(BASE + 32'h10, 0, 0, d, r);
    n_checks++;
    if (d !== 32'h11AA_3344 || r !== 2'b00) begin
      n_fail++;
      $display("FAIL strobe_byte2: rdata=%h rresp=%b required 11aa3344 00", d, r);
    end
    write_txn(BASE + 32'h10, 32'h0000_BEEF, 4'b0011, 0, 0, 0, r);
    void'(model_write(BASE + 32'h10, 32'h0000_BEEF, 4'b0011));
    read_txn(BASE + 32'h10, 0, 0, d, r);
    n_checks++;
    if (d !== 32'h11AA_BEEF) begin
      n_fail++;
      $display("FAIL strobe_half: rdata=%h required 11aabeef", d);
    end
    write_txn(BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0, r);
    n_checks++;
    if (r !== model_write(BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000)) begin
      n_fail++;
      $display("FAIL strobe_none_resp: bresp=%b required 00", r);
    end
    read_txn(BASE + 32'h10, 0, 0, d, r);
    n_checks++;
    if (d !== 32'h11AA_BEEF) begin
      n_fail++;
      $display("FAIL strobe_none_data: rdata=%h required 11aabeef", d);
    end
  endtask

  task automatic test_decoupled();
    logic [31:0] d, e;
    logic [1:0]  r;
    wdata = 32'h5A5A_1234; wstrb = 4'hF; wvalid = 1; bready = 0;
    @(posedge clk); #1;
    wvalid = 0;
    for (int c = 1; c < 3; c++) begin
      n_checks++;
      if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL decoupled_w_held c%0d: wready=%b awready=%b bvalid=%b required 0 1 0", c, wready, awready, bvalid);
      end
      @(posedge clk); #1;
    end
    awaddr = BASE + 32'h30; awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    void'(model_write(BASE + 32'h30, 32'h5A5A_1234, 4'hF));
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
        n_fail++;
        $display("FAIL decoupled_b_hold c%0d: bvalid=%b bresp=%b awready=%b wready=%b required 1 00 0 0", c, bvalid, bresp, awready, wready);
      end
      @(posedge clk); #1;
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    read_txn(BASE + 32'h30, 0, 0, d, r);
    void'(model_read(BASE + 32'h30, e));
    n_checks++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL decoupled_readback: rdata=%h required %h", d, e);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d, e;
    logic [1:0]  r;
    write_txn(BASE, 32'h0BAD_F00D, 4'hF, 0, 0, 0, r);
    void'(model_write(BASE, 32'h0BAD_F00D, 4'hF));
    write_txn(BASE + (DEPTH - 1) * 4, 32'h7777_0001, 4'hF, 0, 0, 0, r);
    void'(model_write(BASE + (DEPTH - 1) * 4, 32'h7777_0001, 4'hF));
    write_txn(BASE + DEPTH * 4, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r);
    n_checks++;
    if (r !== 2'b10) begin
      n_fail++;
      $display("FAIL oor_write_above: bresp=%b required 10", r);
    end
    write_txn(BASE - 4, 32'hEEEE_EEEE, 4'hF, 1, 0, 0, r);
    n_checks++;
    if (r !== 2'b10) begin
      n_fail++;
      $display("FAIL oor_write_below: bresp=%b required 10", r);
    end
    read_txn(BASE, 0, 0, d, r);
    void'(model_read(BASE, e));
    n_checks++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL oor_ram_word0: rdata=%h required %h", d, e);
    end
    read_txn(BASE + (DEPTH - 1) * 4, 0, 0, d, r);
    void'(model_read(BASE + (DEPTH - 1) * 4, e));
    n_checks++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL oor_ram_last: rdata=%h required %h", d, e);
    end
    read_txn(BASE + DEPTH * 4, 0, 0, d, r);
    n_checks++;
    if (r !== 2'b10 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL oor_read: rresp=%b rdata=%h required 10 00000000", r, d);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    logic [1:0]  r;
    write_txn(BASE + 32'h20, 32'h1, 4'hF, 0, 0, 0, r);
    void'(model_write(BASE + 32'h20, 32'h1, 4'hF));
    awaddr = BASE + 32'h20; wdata = 32'h2; wstrb = 4'hF; araddr = BASE + 32'h20;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 0; rready = 0;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    void'(model_write(BASE + 32'h20, 32'h2, 4'hF));
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h1 || bvalid !== 1'b1 || bresp !== 2'b00) begin
      n_fail++;
      $display("FAIL collision_read_first: rvalid=%b rdata=%h bvalid=%b bresp=%b required 1 00000001 1 00", rvalid, rdata, bvalid, bresp);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h1 || rresp !== 2'b00 || arready !== 1'b0) begin
        n_fail++;
        $display("FAIL collision_r_hold c%0d: rvalid=%b rdata=%h rresp=%b arready=%b required 1 00000001 00 0", c, rvalid, rdata, rresp, arready);
      end
    end
    rready = 1; bready = 1;
    @(posedge clk); #1;
    rready = 0; bready = 0;
    read_txn(BASE + 32'h20, 0, 0, d, r);
    n_checks++;
    if (d !== 32'h2) begin
      n_fail++;
      $display("FAIL collision_after: rdata=%h required 00000002", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0]  r;
    awaddr = BASE + 32'h40; wdata = 32'hCAFE_F00D; wstrb = 4'hF; araddr = BASE + 32'h10;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 0; rready = 0;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    void'(model_write(BASE + 32'h40, 32'hCAFE_F00D, 4'hF));
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b0 || rdata !== 32'h0 || bresp !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_async: b/r valid,aw/w/ar ready=%b rdata=%h bresp=%b required 00000 0 00", {bvalid, rvalid, awready, wready, arready}, rdata, bresp);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      n_fail++;
      $display("FAIL reset_mid_release: aw/w/ar ready,b/r valid=%b required 11100", {awready, wready, arready, bvalid, rvalid});
    end
    read_txn(BASE + 32'h40, 0, 0, d, r);
    n_checks++;
    if (d !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL reset_mid_retain: rdata=%h required cafef00d", d);
    end
    wdata = 32'h1111_1111; wstrb = 4'hF; wvalid = 1;
    @(posedge clk); #1;
    wvalid = 0;
    #2 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (wready !== 1'b1 || awready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_clears_held: wready=%b awready=%b required 1 1", wready, awready);
    end
    write_txn(BASE + 32'h44, 32'h2222_2222, 4'hF, 0, 0, 0, r);
    void'(model_write(BASE + 32'h44, 32'h2222_2222, 4'hF));
    read_txn(BASE + 32'h44, 0, 0, d, r);
    n_checks++;
    if (d !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL reset_lost_write: rdata=%h required 22222222", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, e;
    logic [1:0]  r, er;
    logic [33:0] exp_item;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      write_txn(BASE + i * 4, d, 4'hF, 0, 0, 0, r);
      void'(model_write(BASE + i * 4, d, 4'hF));
    end
    for (int i = 0; i < 150; i++) begin
      a = BASE - 16 + $urandom_range(0, DEPTH * 4 + 31);
      if ($urandom_range(0, 1) == 0) begin
        d  = $urandom;
        e  = {28'h0, 4'($urandom_range(0, 15))};
        er = model_write(a, d, e[3:0]);
        write_txn(a, d, e[3:0], $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), r);
        n_checks++;
        if (r !== er) begin
          n_fail++;
          $display("FAIL random_write %0d addr=%h: bresp=%b required %b", i, a, r, er);
        end
      end else begin
        er = model_read(a, e);
        exp_q.push_back({er, e});
        read_txn(a, $urandom_range(0, 2), $urandom_range(0, 2), d, r);
        exp_item = exp_q.pop_front();
        n_checks++;
        if ({r, d} !== exp_item) begin
          n_fail++;
          $display("FAIL random_read %0d addr=%h: rresp/rdata=%b/%h required %b/%h", i, a, r, d, exp_item[33:32], exp_item[31:0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wa, ra, wd, rd, e;
    logic [1:0]  wr, rr, ewr, err;
    int wi, ri;
    for (int i = 0; i < 30; i++) begin
      wi = $urandom_range(0, DEPTH - 1);
      ri = (wi + $urandom_range(1, DEPTH - 1)) % DEPTH;
      wa = BASE + wi * 4;
      ra = BASE + ri * 4;
      wd = $urandom;
      err = model_read(ra, e);
      ewr = model_write(wa, wd, 4'hF);
      fork
        write_txn(wa, wd, 4'hF, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), wr);
        read_txn(ra, $urandom_range(0, 1), $urandom_range(0, 1), rd, rr);
      join
      n_checks++;
      if (wr !== ewr || rr !== err || rd !== e) begin
        n_fail++;
        $display("FAIL overlap %0d: bresp=%b rresp=%b rdata=%h required %b %b %h", i, wr, rr, rd, ewr, err, e);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_word_store();
    test_strobes();
    test_decoupled();
    test_out_of_range();
    test_collision();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_lite_ram_slave.md
Name: axi4_lite_ram_slave

Overview:
- AXI4-Lite responder that terminates data-memory transactions issued by the CPU MEM stage through the peripheral interconnect.
- Word-organised RAM with byte-strobe writes.
- Write and read channels run as independent state machines; out-of-range accesses complete with SLVERR.
- Sits behind the interconnect as the default data-RAM target.

Parameters:
- ADDR_WIDTH, 32, width of awaddr/araddr.
- DEPTH_WORDS, 1024, number of 32-bit RAM words; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- awaddr  in  ADDR_WIDTH  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte enables, bit i -> wdata[8i+7:8i]
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  ADDR_WIDTH  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR
- rvalid  out  1  read data valid
- rready  in  1  read data ready

Behaviour:
- Reset (rst=0, async):
  - awready, wready, arready, bvalid, rvalid = 0; bresp, rresp = 2'b00; rdata = 0.
  - Both FSMs return to IDLE; captured AW/W flags are cleared.
  - RAM contents are not cleared.
  - Reset mid-transaction abandons the transaction: a pending response is dropped, and a write not yet committed is lost.
- Address decode: in_range = (addr >= BASE_ADDR) && (addr < BASE_ADDR + DEPTH_WORDS*4). Word index = (addr - BASE_ADDR) >> 2. addr[1:0] is ignored; wstrb alone selects bytes.
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE:
    - awready = !aw_held; wready = !w_held.
    - An AW handshake latches awaddr and sets aw_held. A W handshake latches wdata/wstrb and sets w_held. AW and W may arrive in either order or in the same cycle.
    - On the edge where both are held (latched earlier or handshaking now): if in_range, write the bytes with wstrb=1 and set bresp=OKAY; else perform no write and set bresp=SLVERR.
    - On that same edge: go to W_RESP, set bvalid=1, clear aw_held and w_held.
  - W_RESP: awready = wready = 0; bvalid and bresp are held stable until bvalid&&bready, then go to W_IDLE.
  - Latency: AW+W in the same cycle -> bvalid high in the next cycle. Best-case throughput is one write per 2 cycles.
  - wstrb=4'b0000 with an in-range address: no bytes change, bresp=OKAY.
- Read FSM, states R_IDLE and R_RESP:
  - R_IDLE: arready=1. On arvalid&&arready, register rdata = RAM[word] if in_range (rresp=OKAY), else rdata=0 (rresp=SLVERR). Go to R_RESP with rvalid=1.
  - R_RESP: arready=0; rdata, rresp and rvalid are held stable until rvalid&&rready, then go to R_IDLE.
  - Latency: AR at edge N -> rvalid high in the cycle after edge N.
- Collision: a write commit and a read capture to the same word on the same edge give read-first behaviour; rdata returns the old contents.
- Channels never stall each other; reads and writes may overlap freely.
- Outputs are registered or derived from state only; no combinational path from any *valid/*ready input to any output.

Test Plan:
- Word store/load: AW+W same cycle, addr=BASE+0x10, wdata=32'hDEADBEEF, wstrb=4'hF -> bvalid next cycle with bresp=00. Then AR to 0x10 -> rvalid next cycle, rdata=DEADBEEF, rresp=00.
- Byte and half strobes: preload 0x10=32'h11223344. Write wstrb=4'b0100, wdata=32'h00AA0000 -> read 32'h11AA3344. Then write wstrb=4'b0011, wdata=32'h0000BEEF -> read 32'h11AABEEF.
- Decoupled channels: W first at cycle 0 (wready then 0), AW at cycle 3 -> commit at cycle 3 edge, bvalid at cycle 4. Hold bready=0 for 5 cycles -> bvalid/bresp stable; awready=wready=0 throughout.
- Out of range: AW/AR to BASE+DEPTH_WORDS*4 -> bresp=2'b10 with RAM unchanged (verified by read-back); rresp=2'b10 with rdata=0.
- Collision and back-pressure: RAM word 0x20=32'h1; write 32'h2 and read 0x20 committed on the same edge -> rdata=32'h1, and a subsequent read returns 32'h2. rready=0 for 4 cycles -> rdata stable, arready=0.
- Reset mid-operation: assert rst while in W_RESP and R_RESP -> bvalid=rvalid=0 immediately (async). After release: readies return, held flags are clear, and RAM retains the previously written data.
